// File: rtl/rx_ring_writer_if.sv
// Wishbone-style point-to-point bus used on both sides of rx_ring_writer.
// The master modport belongs to the initiator (drives address, data and
// strobes). The slave modport belongs to the responder (drives ack).
interface rx_ring_writer_if;
    logic [31:0] adr;
    logic        cyc;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        ack;

    modport master (
        output adr,
        output cyc,
        output we,
        output sel,
        output dat,
        input  ack
    );

    modport slave (
        input  adr,
        input  cyc,
        input  we,
        input  sel,
        input  dat,
        output ack
    );
endinterface

// File: rtl/rx_ring_writer.sv
// rx_ring_writer: buffers bytes received from uart_rx in a small FIFO and
// writes each byte, zero-extended to a 32-bit word, into a RAM ring buffer.
// The block also arbitrates the single RAM port between the CPU, which has
// priority, and its own DMA writes. DMA words are inserted only in IDLE slots
// where the CPU is not requesting the bus.
module rx_ring_writer #(
    parameter logic [31:0] ADR_LL     = 32'h00C00000,
    parameter logic [31:0] ADR_UL     = 32'h00C10000,
    parameter int          FIFO_DEPTH = 4,
    localparam int         LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               i_wb_clk,
    input  logic               i_wb_rst,
    input  logic [7:0]         i_rx_dat,
    input  logic               i_rx_done,
    rx_ring_writer_if.slave    cpu,
    rx_ring_writer_if.master   ram,
    input  logic               i_ovf_clr,
    output logic [31:0]        o_wr_ptr,
    output logic               o_overflow,
    output logic [LVL_W-1:0]   o_fifo_level
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    // Next ring address after a completed word. The add is 32 bits wide;
    // reaching or passing the top wraps to the base.
    function automatic logic [31:0] next_ring_adr(input logic [31:0] cur);
        logic [31:0] sum;
        sum = cur + 32'd4;
        if (sum >= ADR_UL) begin
            return ADR_LL;
        end else begin
            return sum;
        end
    endfunction

    state_t            state_q;
    state_t            state_d;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [AW-1:0]     rd_idx_q;
    logic [AW-1:0]     wr_idx_q;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [31:0]       wr_ptr_q;
    logic [31:0]       wr_ptr_d;
    logic              overflow_q;
    logic              overflow_d;

    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    logic [31:0]       ram_adr_s;
    logic              ram_cyc_s;
    logic              ram_we_s;
    logic [3:0]        ram_sel_s;
    logic [31:0]       ram_dat_s;
    logic              cpu_ack_s;

    assign fifo_empty_s = (level_q == LVL_W'(0));
    assign fifo_full_s  = (level_q == LVL_W'(FIFO_DEPTH));

    // A DMA word retires when the RAM acks it; only then is the head byte
    // released, so an aborted cycle never loses its place in the ring.
    assign pop_s  = (state_q == ST_DMA) && ram.ack && !fifo_empty_s;
    // A byte arriving on a full FIFO still fits if the head leaves this cycle.
    assign push_s = i_rx_done && (!fifo_full_s || pop_s);
    assign drop_s = i_rx_done && fifo_full_s && !pop_s;

    // Arbiter next-state: CPU first, DMA only from IDLE with no CPU request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu.cyc) begin
                    state_d = ST_CPU;
                end else if (!fifo_empty_s) begin
                    state_d = ST_DMA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CPU: begin
                // A CPU that withdraws its cycle without an ack releases the
                // bus too, so the arbiter cannot stick here.
                if (ram.ack || !cpu.cyc) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CPU;
                end
            end
            ST_DMA: begin
                if (ram.ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DMA;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM bus mux: CPU pass-through in IDLE/CPU, fixed byte-write in DMA.
    always_comb begin
        ram_adr_s = 32'h0000_0000;
        ram_cyc_s = 1'b0;
        ram_we_s  = 1'b0;
        ram_sel_s = 4'b0000;
        ram_dat_s = 32'h0000_0000;
        cpu_ack_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The CPU gets the bus in the same cycle it asks for it.
                // A stray RAM ack here is not forwarded.
                if (cpu.cyc) begin
                    ram_adr_s = cpu.adr;
                    ram_cyc_s = 1'b1;
                    ram_we_s  = cpu.we;
                    ram_sel_s = cpu.sel;
                    ram_dat_s = cpu.dat;
                end else begin
                    ram_cyc_s = 1'b0;
                end
            end
            ST_CPU: begin
                ram_adr_s = cpu.adr;
                ram_cyc_s = cpu.cyc;
                ram_we_s  = cpu.we;
                ram_sel_s = cpu.sel;
                ram_dat_s = cpu.dat;
                cpu_ack_s = ram.ack;
            end
            ST_DMA: begin
                ram_adr_s = wr_ptr_q;
                ram_cyc_s = 1'b1;
                ram_we_s  = 1'b1;
                ram_sel_s = 4'b1111;
                ram_dat_s = {24'h00_0000, mem_q[rd_idx_q]};
            end
            default: begin
                ram_cyc_s = 1'b0;
            end
        endcase
    end

    // Reset must silence the bus at once, even while the CPU is requesting,
    // so the strobes are gated directly by the asynchronous reset.
    assign ram.adr = ram_adr_s;
    assign ram.cyc = ram_cyc_s & ~i_wb_rst;
    assign ram.we  = ram_we_s  & ~i_wb_rst;
    assign ram.sel = ram_sel_s;
    assign ram.dat = ram_dat_s;
    assign cpu.ack = cpu_ack_s & ~i_wb_rst;

    // Next values for FIFO level, ring pointer and sticky overflow flag.
    always_comb begin
        level_d    = level_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        if (pop_s) begin
            wr_ptr_d = next_ring_adr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        // A drop in the same cycle as a clear wins, so no loss goes unseen.
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (i_ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Control state: arbiter, FIFO indices/level, ring pointer, overflow.
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_q    <= ST_IDLE;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            level_q    <= '0;
            wr_ptr_q   <= ADR_LL;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            wr_ptr_q   <= wr_ptr_d;
            overflow_q <= overflow_d;
            if (push_s) begin
                wr_idx_q <= wr_idx_q + AW'(1);
            end else begin
                wr_idx_q <= wr_idx_q;
            end
            if (pop_s) begin
                rd_idx_q <= rd_idx_q + AW'(1);
            end else begin
                rd_idx_q <= rd_idx_q;
            end
        end
    end

    // FIFO storage: data only, validity is tracked by the level counter.
    always_ff @(posedge i_wb_clk) begin
        if (push_s) begin
            mem_q[wr_idx_q] <= i_rx_dat;
        end
    end

    assign o_wr_ptr     = wr_ptr_q;
    assign o_overflow   = overflow_q;
    assign o_fifo_level = level_q;

endmodule

// File: tb/tb_rx_ring_writer.sv
// Bench for rx_ring_writer: a servant_ram-like responder, a CPU master with
// several traffic modes, and a scoreboard holding the bytes the ring should
// receive, in order, together with the expected pointer and overflow flag.
module tb_rx_ring_writer;

    localparam logic [31:0] LL    = 32'h00C00000;
    localparam logic [31:0] UL    = 32'h00C10000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_dat = 8'h00;
    logic        rx_done = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [31:0] wr_ptr;
    logic        ovf;
    logic [2:0]  level;

    rx_ring_writer_if cpu_bus();
    rx_ring_writer_if ram_bus();

    rx_ring_writer #(
        .ADR_LL(LL),
        .ADR_UL(UL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_wb_clk(clk),
        .i_wb_rst(rst),
        .i_rx_dat(rx_dat),
        .i_rx_done(rx_done),
        .cpu(cpu_bus),
        .ram(ram_bus),
        .i_ovf_clr(ovf_clr),
        .o_wr_ptr(wr_ptr),
        .o_overflow(ovf),
        .o_fifo_level(level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // servant_ram timing: ack one cycle after cyc, never two in a row.
    always @(posedge clk or posedge rst) begin
        if (rst) ram_bus.ack <= 1'b0;
        else     ram_bus.ack <= ram_bus.cyc && !ram_bus.ack;
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Reference model: the bytes owed to the ring, the next ring address and
    // the sticky flag.
    logic [7:0]  exp_q[$];
    logic [31:0] m_ptr = LL;
    logic        m_ovf = 1'b0;
    int          t_cpu_ack = 0;
    int          t_dma_ack = 0;
    logic        dma_done;
    logic        m_drop;
    logic [7:0]  m_byte;

    // Monitor: compare registered outputs, retire DMA words, then fold in
    // this cycle's inputs.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_ptr = LL;
            m_ovf = 1'b0;
        end else begin
            chk("fifo_level", {29'd0, level}, exp_q.size());
            chk("overflow", {31'd0, ovf}, {31'd0, m_ovf});
            chk("wr_ptr", wr_ptr, m_ptr);
            if (cpu_bus.ack) begin
                chk("cpu_ack_needs_cyc", {31'd0, cpu_bus.cyc}, 32'd1);
                chk("cpu_route_adr", ram_bus.adr, cpu_bus.adr);
                chk("cpu_route_we", {31'd0, ram_bus.we}, {31'd0, cpu_bus.we});
                t_cpu_ack = cyc_n;
            end
            dma_done = ram_bus.cyc && ram_bus.ack && ram_bus.we &&
                       (ram_bus.adr >= LL) && (ram_bus.adr < UL);
            if (dma_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dma_unexpected actual=adr %h dat %h expected=no write", ram_bus.adr, ram_bus.dat);
                end else begin
                    m_byte = exp_q.pop_front();
                    chk("dma_adr", ram_bus.adr, m_ptr);
                    chk("dma_dat", ram_bus.dat, {24'h000000, m_byte});
                    chk("dma_sel", {28'd0, ram_bus.sel}, 32'h0000000F);
                    chk("dma_no_cpu_ack", {31'd0, cpu_bus.ack}, 32'd0);
                    m_ptr = ((m_ptr + 32'd4) >= UL) ? LL : (m_ptr + 32'd4);
                    t_dma_ack = cyc_n;
                end
            end
            m_drop = 1'b0;
            if (rx_done) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(rx_dat);
                else m_drop = 1'b1;
            end
            if (ovf_clr) m_ovf = 1'b0;
            if (m_drop)  m_ovf = 1'b1;
        end
    end

    // CPU master. Modes: 0 idle, 1 random, 2 back-to-back, 3 single read,
    // 4 hold a request while reset is asserted.
    int   cpu_mode = 4;
    bit   pend = 1'b0;
    int   waitc = 0;
    logic ackd;

    initial begin
        cpu_bus.adr = 32'h0;
        cpu_bus.cyc = 1'b0;
        cpu_bus.we  = 1'b0;
        cpu_bus.sel = 4'h0;
        cpu_bus.dat = 32'h0;
        forever begin
            @(negedge clk);
            ackd = cpu_bus.ack;
            @(posedge clk);
            #1;
            if (rst) begin
                pend = 1'b0;
                cpu_bus.cyc = (cpu_mode == 4);
                cpu_bus.we  = (cpu_mode == 4);
            end else begin
                if (pend) begin
                    waitc++;
                    if (ackd) begin
                        chk("cpu_wait_bound", {31'd0, (waitc <= 6)}, 32'd1);
                        pend = 1'b0;
                        cpu_bus.cyc = 1'b0;
                    end else if (waitc > 30) begin
                        checks++;
                        errors++;
                        $display("FAIL cpu_ack_timeout actual=no ack after %0d cycles expected=ack", waitc);
                        pend = 1'b0;
                        cpu_bus.cyc = 1'b0;
                    end
                end
                if (!pend && (cpu_mode == 2 || cpu_mode == 3 ||
                              (cpu_mode == 1 && $urandom_range(0, 3) == 0))) begin
                    pend = 1'b1;
                    waitc = 0;
                    cpu_bus.adr = {16'h0000, 16'($urandom) & 16'hFFFC};
                    cpu_bus.we  = (cpu_mode == 3) ? 1'b0 : 1'($urandom_range(0, 1));
                    cpu_bus.sel = 4'($urandom);
                    cpu_bus.dat = $urandom;
                    cpu_bus.cyc = 1'b1;
                end
            end
        end
    end

    task automatic rx_pulse(input logic [7:0] b);
        rx_dat  = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (level == 3'd0 && !ram_bus.cyc && !cpu_bus.cyc) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL drain_timeout actual=level %0d expected=0", level);
        end
    endtask

    int  n_fill;
    bit  found;

    initial begin
        // Reset state, with a CPU request present to show the bus stays quiet.
        repeat (3) tick();
        #1;
        chk("rst_ram_cyc", {31'd0, ram_bus.cyc}, 32'd0);
        chk("rst_ram_we", {31'd0, ram_bus.we}, 32'd0);
        chk("rst_cpu_ack", {31'd0, cpu_bus.ack}, 32'd0);
        chk("rst_wr_ptr", wr_ptr, LL);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        cpu_mode = 0;
        tick();
        @(posedge clk);
        #3 rst = 1'b0;
        tick();

        // 1: single byte, idle bus, 2-cycle latency to the RAM strobe.
        rx_pulse(8'h41);
        chk("t1_cyc_early", {31'd0, ram_bus.cyc}, 32'd0);
        tick();
        chk("t1_cyc", {31'd0, ram_bus.cyc}, 32'd1);
        chk("t1_we", {31'd0, ram_bus.we}, 32'd1);
        chk("t1_adr", ram_bus.adr, LL);
        chk("t1_dat", ram_bus.dat, 32'h00000041);
        chk("t1_sel", {28'd0, ram_bus.sel}, 32'h0000000F);
        tick();
        chk("t1_cpu_ack", {31'd0, cpu_bus.ack}, 32'd0);
        tick();
        chk("t1_ptr", wr_ptr, 32'h00C00004);

        // 2: CPU read in flight when a byte arrives; CPU first, then DMA.
        cpu_mode = 3;
        for (int k = 0; k < 10; k++) begin
            if (cpu_bus.cyc) break;
            tick();
        end
        cpu_mode = 0;
        rx_pulse(8'h55);
        drain();
        chk("t2_order_gap", t_dma_ack - t_cpu_ack, 32'd3);

        // 3: bus monopolised by the CPU, five bytes into a four-deep FIFO.
        cpu_mode = 2;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            rx_pulse(8'h10 + 8'(i));
            tick();
        end
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        chk("t3_level", {29'd0, level}, 32'd4);
        cpu_mode = 0;
        drain();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", {31'd0, ovf}, 32'd0);

        // 5: full FIFO, byte arrives on the cycle of a DMA ack.
        cpu_mode = 2;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            rx_pulse(8'h20 + 8'(i));
        end
        cpu_mode = 0;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (ram_bus.cyc && ram_bus.ack && ram_bus.we && ram_bus.adr >= LL && level == 3'd4) begin
                rx_pulse(8'hA5);
                chk("t5_level", {29'd0, level}, 32'd4);
                chk("t5_ovf", {31'd0, ovf}, 32'd0);
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL t5_no_full_ack actual=not seen expected=DMA ack with level 4");
        end
        drain();

        // Random mix of CPU traffic, received bytes and flag clears.
        cpu_mode = 1;
        for (int k = 0; k < 500; k++) begin
            rx_done = ($urandom_range(0, 2) == 0);
            rx_dat  = 8'($urandom);
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        rx_done = 1'b0;
        ovf_clr = 1'b0;
        cpu_mode = 0;
        drain();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // 4: walk the pointer to the last ring word and wrap it.
        n_fill = int'((32'h00C0FFFC - m_ptr) >> 2);
        for (int k = 0; k < n_fill; k++) begin
            rx_pulse(8'($urandom));
            tick();
            tick();
        end
        drain();
        chk("t4_pre_wrap", wr_ptr, 32'h00C0FFFC);
        rx_pulse(8'h7E);
        drain();
        chk("t4_wrapped", wr_ptr, LL);

        // 6: reset while a DMA word is on the bus.
        rx_pulse(8'h66);
        for (int k = 0; k < 10; k++) begin
            if (ram_bus.cyc && ram_bus.we) break;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        chk("t6_cyc_now", {31'd0, ram_bus.cyc}, 32'd0);
        chk("t6_we_now", {31'd0, ram_bus.we}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        tick();
        chk("t6_ptr", wr_ptr, LL);
        chk("t6_level", {29'd0, level}, 32'd0);
        rx_pulse(8'h77);
        drain();
        chk("t6_resume_ptr", wr_ptr, 32'h00C00004);

        chk("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
